// File: rtl/ab_rule_checker.sv
// Purpose : checks each a/b sample against AND/OR/XOR rules, keeps saturating
//           per-rule fail counts, captures the first failure, flags run completion.
// Latency : all results registered; a sample is reflected 1 cycle after acceptance.
// Backpr. : none; in_valid gaps simply stall the run, samples outside RUN are dropped.
//
// Ports:
//   clk, rst_n          clock (posedge) and async active-low reset
//   start               pulse, begins a run from IDLE or DONE (ignored in RUN)
//   in_valid/in_a/in_b  sample stream
//   busy / done         RUN / DONE state indicators (done held until next start)
//   sample_cnt          samples accepted this run
//   fail_*_cnt          saturating per-rule fail counts
//   any_fail            sticky: some rule failed this run
//   first_fail_idx/vec  index and failing-rule vector ([0]=AND [1]=OR [2]=XOR) of first failure
module ab_rule_checker #(
  parameter int NUM_SAMPLES = 10,
  parameter int IDX_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] fail_and_cnt,
  output logic [CNT_W-1:0] fail_or_cnt,
  output logic [CNT_W-1:0] fail_xor_cnt,
  output logic             any_fail,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t state, state_nxt;

  logic       accept;
  logic       start_go;
  logic       last_sample;
  logic [2:0] fail_vec;

  // start only takes effect outside RUN; samples only count inside RUN, so the
  // start cycle itself never accepts a sample.
  assign accept      = (state == ST_RUN) && in_valid;
  assign start_go    = start && (state != ST_RUN);
  assign last_sample = accept && (sample_cnt == LAST_IDX);

  // A set bit means the rule's expected value was 0 for this sample.
  assign fail_vec = {~(in_a ^ in_b), ~(in_a | in_b), ~(in_a & in_b)};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)       state_nxt = ST_RUN;
      ST_RUN:  if (last_sample) state_nxt = ST_DONE;
      ST_DONE: if (start)       state_nxt = ST_RUN;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Result datapath: cleared on an honoured start, updated per accepted
  // sample, and otherwise held (which keeps DONE results stable).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt     <= '0;
      fail_and_cnt   <= '0;
      fail_or_cnt    <= '0;
      fail_xor_cnt   <= '0;
      any_fail       <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vec <= 3'b000;
    end else if (start_go) begin
      sample_cnt     <= '0;
      fail_and_cnt   <= '0;
      fail_or_cnt    <= '0;
      fail_xor_cnt   <= '0;
      any_fail       <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vec <= 3'b000;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (fail_vec[0] && (fail_and_cnt != CNT_MAX)) fail_and_cnt <= fail_and_cnt + 1'b1;
      if (fail_vec[1] && (fail_or_cnt  != CNT_MAX)) fail_or_cnt  <= fail_or_cnt  + 1'b1;
      if (fail_vec[2] && (fail_xor_cnt != CNT_MAX)) fail_xor_cnt <= fail_xor_cnt + 1'b1;
      // Only the first failing sample of a run is captured.
      if (!any_fail && (fail_vec != 3'b000)) begin
        any_fail       <= 1'b1;
        first_fail_idx <= sample_cnt;
        first_fail_vec <= fail_vec;
      end
    end
  end

endmodule

// File: tb/tb_ab_rule_checker.sv
module tb_ab_rule_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Three instances: default (10 samples), short run (4), saturation (20 samples, 4-bit counters).
  logic start_s [3];
  logic vld_s   [3];
  logic a_s     [3];
  logic b_s     [3];

  logic       busy_o [3];
  logic       done_o [3];
  logic [7:0] sc_o   [3];
  logic       anyf_o [3];
  logic [7:0] fi_o   [3];
  logic [2:0] fv_o   [3];
  logic [7:0] fa0, fo0, fx0, fa1, fo1, fx1;
  logic [3:0] fa2, fo2, fx2;

  ab_rule_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(vld_s[0]), .in_a(a_s[0]), .in_b(b_s[0]),
    .busy(busy_o[0]), .done(done_o[0]), .sample_cnt(sc_o[0]),
    .fail_and_cnt(fa0), .fail_or_cnt(fo0), .fail_xor_cnt(fx0),
    .any_fail(anyf_o[0]), .first_fail_idx(fi_o[0]), .first_fail_vec(fv_o[0]));

  ab_rule_checker #(.NUM_SAMPLES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(vld_s[1]), .in_a(a_s[1]), .in_b(b_s[1]),
    .busy(busy_o[1]), .done(done_o[1]), .sample_cnt(sc_o[1]),
    .fail_and_cnt(fa1), .fail_or_cnt(fo1), .fail_xor_cnt(fx1),
    .any_fail(anyf_o[1]), .first_fail_idx(fi_o[1]), .first_fail_vec(fv_o[1]));

  ab_rule_checker #(.NUM_SAMPLES(20), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_valid(vld_s[2]), .in_a(a_s[2]), .in_b(b_s[2]),
    .busy(busy_o[2]), .done(done_o[2]), .sample_cnt(sc_o[2]),
    .fail_and_cnt(fa2), .fail_or_cnt(fo2), .fail_xor_cnt(fx2),
    .any_fail(anyf_o[2]), .first_fail_idx(fi_o[2]), .first_fail_vec(fv_o[2]));

  int num_s [3] = '{10, 4, 20};
  int max_c [3] = '{255, 255, 15};

  int errors = 0;
  int checks = 0;

  // Sample list of the current run, fed to both the DUT and the model.
  bit qa[$];
  bit qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt_and(input int d);
    case (d) 0: return fa0; 1: return fa1; default: return {4'b0, fa2}; endcase
  endfunction
  function automatic logic [7:0] cnt_or(input int d);
    case (d) 0: return fo0; 1: return fo1; default: return {4'b0, fo2}; endcase
  endfunction
  function automatic logic [7:0] cnt_xor(input int d);
    case (d) 0: return fx0; 1: return fx1; default: return {4'b0, fx2}; endcase
  endfunction

  // Check every result output of instance d against the rule model applied to qa/qb.
  task automatic check_results(input int d, input string tag);
    int n_and = 0, n_or = 0, n_xor = 0;
    int first = -1;
    logic [2:0] vec = 3'b000;
    for (int i = 0; i < qa.size(); i++) begin
      bit fand = !(qa[i] && qb[i]);
      bit forr = !(qa[i] || qb[i]);
      bit fxor = (qa[i] == qb[i]);
      n_and += fand;
      n_or  += forr;
      n_xor += fxor;
      if (first < 0 && (fand || forr || fxor)) begin
        first = i;
        vec = {fxor, forr, fand};
      end
    end
    if (n_and > max_c[d]) n_and = max_c[d];
    if (n_or  > max_c[d]) n_or  = max_c[d];
    if (n_xor > max_c[d]) n_xor = max_c[d];
    chk({tag, ".sample_cnt"}, 32'(sc_o[d]), 32'(qa.size()));
    chk({tag, ".fail_and"},   32'(cnt_and(d)), 32'(n_and));
    chk({tag, ".fail_or"},    32'(cnt_or(d)),  32'(n_or));
    chk({tag, ".fail_xor"},   32'(cnt_xor(d)), 32'(n_xor));
    chk({tag, ".any_fail"},   32'(anyf_o[d]), 32'(first >= 0));
    chk({tag, ".first_idx"},  32'(fi_o[d]), (first >= 0) ? 32'(first) : 32'd0);
    chk({tag, ".first_vec"},  32'(fv_o[d]), 32'(vec));
  endtask

  // Start pulse with a junk (0,0) sample on the start cycle that must be ignored.
  task automatic start_run(input int d, input string tag);
    start_s[d] = 1'b1; vld_s[d] = 1'b1; a_s[d] = 1'b0; b_s[d] = 1'b0;
    @(posedge clk); #1;
    start_s[d] = 1'b0; vld_s[d] = 1'b0;
    chk({tag, ".busy_after_start"}, 32'(busy_o[d]), 32'd1);
    chk({tag, ".done_after_start"}, 32'(done_o[d]), 32'd0);
    chk({tag, ".cleared_cnt"},      32'(sc_o[d]), 32'd0);
    chk({tag, ".cleared_anyf"},     32'(anyf_o[d]), 32'd0);
    chk({tag, ".cleared_and"},      32'(cnt_and(d)), 32'd0);
  endtask

  // Feed sample i of qa/qb after 'gaps' idle cycles (with start pulses if mid_start).
  task automatic feed(input int d, input int i, input int gaps, input bit mid_start, input string tag);
    for (int g = 0; g < gaps; g++) begin
      vld_s[d] = 1'b0; start_s[d] = mid_start; a_s[d] = 1'($urandom); b_s[d] = 1'($urandom);
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      chk({tag, ".stall_cnt"},  32'(sc_o[d]), 32'(i));
      chk({tag, ".stall_busy"}, 32'(busy_o[d]), 32'd1);
    end
    vld_s[d] = 1'b1; a_s[d] = qa[i]; b_s[d] = qb[i];
    @(posedge clk); #1;
    vld_s[d] = 1'b0;
    chk({tag, ".cnt"}, 32'(sc_o[d]), 32'(i + 1));
    if (i == num_s[d] - 1) begin
      chk({tag, ".done_end"}, 32'(done_o[d]), 32'd1);
      chk({tag, ".busy_end"}, 32'(busy_o[d]), 32'd0);
    end else begin
      chk({tag, ".done_mid"}, 32'(done_o[d]), 32'd0);
      chk({tag, ".busy_mid"}, 32'(busy_o[d]), 32'd1);
    end
  endtask

  // Complete run: start, all samples, results, then DONE hold with stray samples/no start.
  task automatic do_run(input int d, input int max_gap, input bit mid_start, input string tag);
    start_run(d, tag);
    for (int i = 0; i < qa.size(); i++)
      feed(d, i, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, mid_start, tag);
    check_results(d, tag);
    for (int h = 0; h < 3; h++) begin
      vld_s[d] = 1'b1; a_s[d] = 1'($urandom); b_s[d] = 1'($urandom);
      @(posedge clk); #1;
    end
    vld_s[d] = 1'b0;
    chk({tag, ".hold_done"}, 32'(done_o[d]), 32'd1);
    check_results(d, {tag, ".hold"});
  endtask

  task automatic set_samples(input int n, input int pattern);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin
      case (pattern)
        0: begin qa.push_back(1'b1); qb.push_back(1'b1); end
        1: begin qa.push_back(i % 2 == 0); qb.push_back(i % 2 == 1); end
        2: begin qa.push_back(1'b0); qb.push_back(1'b0); end
        default: begin qa.push_back(1'($urandom)); qb.push_back(1'($urandom)); end
      endcase
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; vld_s[d] = 1'b0; a_s[d] = 1'b0; b_s[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("reset.busy", 32'(busy_o[d]), 32'd0);
      chk("reset.done", 32'(done_o[d]), 32'd0);
      check_results(d, "reset");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle: start-less samples are ignored.
    vld_s[0] = 1'b1; a_s[0] = 1'b0; b_s[0] = 1'b0;
    @(posedge clk); #1;
    vld_s[0] = 1'b0;
    chk("idle.ignore_cnt", 32'(sc_o[0]), 32'd0);
    chk("idle.busy", 32'(busy_o[0]), 32'd0);

    // Directed: mixed 4-sample run.
    qa = '{1, 1, 0, 0}; qb = '{1, 0, 0, 1};
    do_run(1, 0, 1'b0, "mix4");

    // All (1,1), alternating (1,0)/(0,1).
    set_samples(10, 0); do_run(0, 0, 1'b0, "all11");
    set_samples(10, 1); do_run(0, 0, 1'b0, "alt");

    // Saturation of 4-bit counters.
    set_samples(20, 2); do_run(2, 0, 1'b0, "sat");

    // Gaps plus start pulses mid-run; first failure must be kept.
    qa = '{1, 1, 1, 1}; qb = '{1, 1, 1, 0};
    do_run(1, 2, 1'b1, "gapstart");

    // Randomized runs on the default instance, each starting from DONE.
    for (int r = 0; r < 6; r++) begin
      set_samples(10, 3);
      do_run(0, 2, r[0], $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a run.
    set_samples(10, 3);
    start_run(0, "rst");
    for (int i = 0; i < 3; i++) feed(0, i, 0, 1'b0, "rst");
    rst_n = 1'b0;
    #2;
    chk("rst_async.busy", 32'(busy_o[0]), 32'd0);
    chk("rst_async.done", 32'(done_o[0]), 32'd0);
    qa.delete(); qb.delete();
    check_results(0, "rst_async");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after.busy", 32'(busy_o[0]), 32'd0);
    chk("rst_after.cnt",  32'(sc_o[0]), 32'd0);

    // Fresh run after reset proceeds normally.
    set_samples(10, 3); do_run(0, 1, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
